// File: rtl/operand_sequencer_pkg.sv
// Shared sizing defaults and FSM state encoding for the operand sequencer.
// No logic; constants and types only.
// Imported by the sequencer top and its table sub-module.
package operand_sequencer_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_ADDR_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

endpackage

// File: rtl/operand_table.sv
// Operand storage: DEPTH x DATA_W register array cleared by reset.
// Write lands at the clock edge; read is combinational (0 cycles).
// No flow control; the caller gates the write strobe.
module operand_table
    import operand_sequencer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Clear every entry on reset, otherwise take the gated write.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/operand_sequencer.sv
// Plays a loaded operand table out over a valid/ready stream, optionally looping.
// First word is valid 1 cycle after an accepted start; then one word per transfer.
// out_ready low holds out_data and index stable; abort drops valid the next cycle.
module operand_sequencer
    import operand_sequencer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W:0]   len,
    input  logic              loop,
    input  logic              start,
    input  logic              abort,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              loop_q, loop_d;
    logic              valid_d, busy_d, done_d;
    logic              data_ld;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W:0]   len_c;
    logic              last;
    logic              table_we;

    // Requests beyond the table size play the whole table once.
    assign len_c    = (len > LEN_MAX) ? LEN_MAX : len;
    // Compared in ADDR_W+1 bits so a full-table run ends at index DEPTH-1.
    assign last     = ({1'b0, idx_q} == (len_q - (ADDR_W+1)'(1)));
    // The table is frozen while a run is in progress.
    assign table_we = wr_en && (state_q == ST_IDLE);

    operand_table #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_table (
        .clock   (clock),
        .reset   (reset),
        .we      (table_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Next-state, index and output decisions; registered below.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        loop_d  = loop_q;
        valid_d = out_valid;
        busy_d  = busy;
        done_d  = 1'b0;
        data_ld = 1'b0;
        rd_addr = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (len_c == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_PLAY;
                        idx_d   = '0;
                        len_d   = len_c;
                        loop_d  = loop;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        data_ld = 1'b1;
                        rd_addr = '0;
                    end
                end
            end
            ST_PLAY: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (out_valid && out_ready) begin
                    if (!last) begin
                        idx_d   = idx_q + ADDR_W'(1);
                        rd_addr = idx_q + ADDR_W'(1);
                        data_ld = 1'b1;
                    end else if (loop_q) begin
                        idx_d   = '0;
                        rd_addr = '0;
                        data_ld = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; out_data only changes when a new word loads.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            loop_q    <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_data  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            loop_q    <= loop_d;
            out_valid <= valid_d;
            busy      <= busy_d;
            done      <= done_d;
            if (data_ld) begin
                out_data <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer: load, play, stall, loop, abort, clamp, reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Expected values are hand-derived from the table contents below.
module tb_operand_sequencer;

    logic       clock;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] len;
    logic       loop;
    logic       start;
    logic       abort;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [7:0] tbl [8];
    logic       rdy_pat [5];
    logic [7:0] stall_exp [5];
    int         xfers;

    operand_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .len       (len),
        .loop      (loop),
        .start     (start),
        .abort     (abort),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tbl[0] = 8'h0B; tbl[1] = 8'h09; tbl[2] = 8'h0D; tbl[3] = 8'h06;
        tbl[4] = 8'h07; tbl[5] = 8'h04; tbl[6] = 8'h0E; tbl[7] = 8'h02;
        rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b0;
        rdy_pat[3] = 1'b1; rdy_pat[4] = 1'b1;
        stall_exp[0] = 8'h0B; stall_exp[1] = 8'h09; stall_exp[2] = 8'h09;
        stall_exp[3] = 8'h09; stall_exp[4] = 8'h0D;

        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        len = '0; loop = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        #1;
        tick(); tick();
        reset = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data", out_data, 0);

        // Load the table.
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = tbl[i];
            tick();
        end
        wr_en = 1'b0;

        // Full table, no loop, consumer always ready.
        len = 4'd8; loop = 1'b0; start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        check("t1_busy", busy, 1);
        for (int i = 0; i < 8; i++) begin
            check("t1_valid", out_valid, 1);
            check("t1_data", out_data, 32'(tbl[i]));
            check("t1_nodone", done, 0);
            tick();
        end
        check("t1_done", done, 1);
        check("t1_valid_end", out_valid, 0);
        check("t1_busy_end", busy, 0);
        check("t1_data_hold", out_data, 32'h02);
        tick();
        check("t1_done_once", done, 0);
        check("t1_busy_after", busy, 0);

        // len=3 with stalls.
        len = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        xfers = 0;
        for (int k = 0; k < 5; k++) begin
            check("t2_valid", out_valid, 1);
            check("t2_data", out_data, 32'(stall_exp[k]));
            out_ready = rdy_pat[k];
            if (out_valid && out_ready) xfers++;
            tick();
        end
        check("t2_xfers", xfers, 3);
        check("t2_done", done, 1);
        check("t2_valid_end", out_valid, 0);
        tick();

        // len=2 looping, then abort.
        len = 4'd2; loop = 1'b1; start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0; loop = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check("t3_valid", out_valid, 1);
            check("t3_data", out_data, (k % 2 == 0) ? 32'h0B : 32'h09);
            check("t3_nodone", done, 0);
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t3_abort_valid", out_valid, 0);
        check("t3_abort_busy", busy, 0);
        check("t3_abort_done", done, 0);
        tick();
        check("t3_abort_done2", done, 0);

        // len=0: no words, immediate done.
        len = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_len0_done", done, 1);
        check("t4_len0_valid", out_valid, 0);
        check("t4_len0_busy", busy, 0);
        tick();
        check("t4_len0_done_off", done, 0);
        check("t4_len0_valid2", out_valid, 0);

        // len=12 clamps to the table size.
        len = 4'd12; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("t4_clamp_valid", out_valid, 1);
            check("t4_clamp_data", out_data, 32'(tbl[i]));
            tick();
        end
        check("t4_clamp_done", done, 1);
        check("t4_clamp_valid_end", out_valid, 0);
        tick();

        // Write during playback is ignored.
        len = 4'd3; out_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        check("t5_hold_data", out_data, 32'h0B);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_abort_busy", busy, 0);
        len = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_table_kept", out_data, 32'h0B);
        out_ready = 1'b1;
        tick();
        check("t5_len1_done", done, 1);

        // start and abort together in IDLE: nothing starts.
        len = 4'd4; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("t5_sa_busy", busy, 0);
        check("t5_sa_valid", out_valid, 0);
        check("t5_sa_done", done, 0);

        // Reset in the middle of a run.
        len = 4'd8; start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        check("t6_w0", out_data, 32'h0B);
        tick();
        tick();
        tick();
        check("t6_w3", out_data, 32'h06);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_data", out_data, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        len = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_cleared_valid", out_valid, 1);
        check("t6_cleared_data", out_data, 0);
        tick();
        check("t6_cleared_done", done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
